// File: rtl/tag_return_arbiter.sv
// Collects freed reservation-station tags from several completion sources and
// writes them one per cycle, round-robin, into the free-tag FIFO.
module tag_return_arbiter #(
  parameter int TAG_WIDTH = 6,
  parameter int NUM_SRC   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]     src_tag,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic                             ren_tf,
  input  logic                             ff_tf,
  output logic [TAG_WIDTH-1:0]             cdb_tag_tf,
  output logic                             cdb_tag_tf_valid,
  output logic [$clog2(NUM_SRC+1)-1:0]     pending
);

  localparam int RR_W  = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(NUM_SRC + 1);

  logic [NUM_SRC-1:0]   r_held_v;
  logic [TAG_WIDTH-1:0] r_held_tag [NUM_SRC];
  logic [RR_W-1:0]      r_rr;
  logic [CNT_W-1:0]     r_pending;

  logic                 w_can_issue;
  logic [RR_W-1:0]      w_idx;
  logic [RR_W-1:0]      w_winner;
  logic [RR_W-1:0]      w_rr_next;
  logic [NUM_SRC-1:0]   w_accept;
  logic [NUM_SRC-1:0]   w_held_v_next;
  logic [CNT_W-1:0]     w_count;

  // Walk the offsets from farthest to nearest so the slot closest to r_rr wins.
  always_comb begin
    w_idx    = '0;
    w_winner = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_idx = RR_W'((int'(r_rr) + k) % NUM_SRC);
      if (r_held_v[w_idx]) w_winner = w_idx;
    end
  end

  assign w_can_issue = (|r_held_v) & ~ren_tf & ~ff_tf & ~flush;
  assign w_rr_next   = (w_winner == RR_W'(NUM_SRC - 1)) ? '0 : w_winner + RR_W'(1);

  // A slot being issued this cycle can take a new tag at the same edge.
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = ~flush & (~r_held_v[i] | (w_can_issue & (w_winner == RR_W'(i))));
    end
  end

  assign w_accept = src_valid & src_ready;

  always_comb begin
    w_held_v_next = r_held_v;
    if (w_can_issue) w_held_v_next[w_winner] = 1'b0;
    w_held_v_next = w_held_v_next | w_accept;
    if (flush) w_held_v_next = '0;
    w_count = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_count = w_count + CNT_W'(w_held_v_next[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_held_v  <= '0;
      r_rr      <= '0;
      r_pending <= '0;
      // NOTE: the tag slots are cleared on reset so cdb_tag_tf never carries X.
      for (int i = 0; i < NUM_SRC; i++) r_held_tag[i] <= '0;
    end else begin
      r_held_v  <= w_held_v_next;
      r_pending <= w_count;
      if (flush)            r_rr <= '0;
      else if (w_can_issue) r_rr <= w_rr_next;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_accept[i]) r_held_tag[i] <= src_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign cdb_tag_tf_valid = w_can_issue;
  assign cdb_tag_tf       = w_can_issue ? r_held_tag[w_winner] : '0;
  assign pending          = r_pending;

endmodule

// File: tb/tb_tag_return_arbiter.sv
// Scoreboard bench for tag_return_arbiter: an array/queue reference model
// predicts FIFO writes; a negedge monitor compares every write it observes.
module tb_tag_return_arbiter;
  localparam int TW = 6;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [N-1:0]    src_valid;
  logic [N*TW-1:0] src_tag;
  logic [N-1:0]    src_ready;
  logic            ren_tf;
  logic            ff_tf;
  logic [TW-1:0]   cdb_tag_tf;
  logic            cdb_tag_tf_valid;
  logic [2:0]      pending;

  tag_return_arbiter #(.TAG_WIDTH(TW), .NUM_SRC(N)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_tag(src_tag), .src_ready(src_ready),
    .ren_tf(ren_tf), .ff_tf(ff_tf),
    .cdb_tag_tf(cdb_tag_tf), .cdb_tag_tf_valid(cdb_tag_tf_valid),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   m_v   [N];
  int   m_tag [N];
  int   m_rr;
  logic exp_valid;
  int   exp_q [$];

  int          offer_v   [N];
  logic [TW-1:0] offer_tag [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*TW-1:0] pack(input int t0, input int t1, input int t2, input int t3);
    logic [N*TW-1:0] r;
    r = '0;
    r[0*TW +: TW] = TW'(t0);
    r[1*TW +: TW] = TW'(t1);
    r[2*TW +: TW] = TW'(t2);
    r[3*TW +: TW] = TW'(t3);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_v[i]   = 0;
      m_tag[i] = 0;
    end
    m_rr = 0;
    exp_q.delete();
    exp_valid = 1'b0;
  endtask

  // Entered at posedge+1; applies one cycle of stimulus, predicts, and returns at the next posedge+1.
  task automatic cycle(input logic fl, input logic [N-1:0] v, input logic [N*TW-1:0] t,
                       input logic ren, input logic ff, output logic [N-1:0] acc);
    int cnt;
    int win;
    int idx;
    logic can;
    logic [N-1:0] rdy;
    flush = fl; src_valid = v; src_tag = t; ren_tf = ren; ff_tf = ff;
    #1;
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += m_v[i];
    check("pending", 32'(pending), 32'(cnt));
    win = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (win < 0 && m_v[idx] != 0) win = idx;
    end
    can = (win >= 0) && !ren && !ff && !fl;
    for (int i = 0; i < N; i++) rdy[i] = !fl && (m_v[i] == 0 || (can && win == i));
    check("src_ready", 32'(src_ready), 32'(rdy));
    exp_valid = can;
    if (can) exp_q.push_back(m_tag[win]);
    if (fl) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_rr = 0;
    end else begin
      if (can) begin
        m_v[win] = 0;
        m_rr = (win + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (v[i] && rdy[i]) begin
          m_v[i]   = 1;
          m_tag[i] = int'(t[i*TW +: TW]);
        end
      end
    end
    acc = v & rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [N-1:0] a;
    for (int j = 0; j < n; j++) cycle(1'b0, '0, '0, 1'b0, 1'b0, a);
  endtask

  // Monitor: compares every observed write strobe and tag against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("wr_valid", 32'(cdb_tag_tf_valid), 32'(exp_valid));
      if (cdb_tag_tf_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected: got tag 0x%0h expected no write at %0t", cdb_tag_tf, $time);
        end else begin
          check("wr_tag", 32'(cdb_tag_tf), 32'(exp_q.pop_front()));
        end
      end else begin
        check("idle_tag", 32'(cdb_tag_tf), 32'd0);
      end
    end
  end

  initial begin
    logic [N-1:0] acc;
    reset = 1'b1; flush = 1'b0; src_valid = '0; src_tag = '0; ren_tf = 1'b0; ff_tf = 1'b0;
    model_clear();
    #12;
    check("rst_valid", 32'(cdb_tag_tf_valid), 32'd0);
    check("rst_tag",   32'(cdb_tag_tf), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ready", 32'(src_ready), 32'hF);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single source, one-cycle latency
    cycle(1'b0, 4'b0001, pack(6'h2A, 0, 0, 0), 1'b0, 1'b0, acc);
    idle(2);

    // Round-robin over all sources, then wrap back to source 0
    cycle(1'b0, 4'b1111, pack(1, 2, 3, 4), 1'b0, 1'b0, acc);
    idle(4);
    cycle(1'b0, 4'b1001, pack(9, 0, 0, 12), 1'b0, 1'b0, acc);
    idle(2);

    // Read collision holds the winner
    cycle(1'b0, 4'b0110, pack(0, 6'h05, 6'h06, 0), 1'b1, 1'b0, acc);
    cycle(1'b0, 4'b0000, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, 4'b0000, '0, 1'b1, 1'b0, acc);
    idle(3);

    // Full FIFO: slots fill, then drain with same-cycle refill
    cycle(1'b0, 4'b1111, pack(10, 11, 12, 13), 1'b0, 1'b1, acc);
    cycle(1'b0, 4'b1111, pack(20, 21, 22, 23), 1'b0, 1'b1, acc);
    for (int j = 0; j < 4; j++) cycle(1'b0, 4'b1111, pack(20, 21, 22, 23), 1'b0, 1'b0, acc);
    idle(5);

    // Flush discards held tags
    cycle(1'b0, 4'b0111, pack(30, 31, 32, 0), 1'b0, 1'b1, acc);
    cycle(1'b1, 4'b1111, pack(40, 41, 42, 43), 1'b0, 1'b0, acc);
    idle(3);

    // Asynchronous reset mid-operation
    cycle(1'b0, 4'b1111, pack(50, 51, 52, 53), 1'b0, 1'b1, acc);
    src_valid = '0; ff_tf = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(cdb_tag_tf_valid), 32'd0);
    check("mid_rst_tag",   32'(cdb_tag_tf), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_ready", 32'(src_ready), 32'hF);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    // Randomised traffic: sources hold their tag until it is accepted
    for (int i = 0; i < N; i++) begin
      offer_v[i] = 0;
      offer_tag[i] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] v;
      logic [N*TW-1:0] t;
      for (int i = 0; i < N; i++) begin
        if (offer_v[i] == 0 && $urandom_range(2, 0) == 0) begin
          offer_v[i]   = 1;
          offer_tag[i] = TW'($urandom());
        end
        v[i] = (offer_v[i] != 0);
        t[i*TW +: TW] = offer_tag[i];
      end
      cycle(($urandom_range(39, 0) == 0), v, t,
            ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) == 0), acc);
      for (int i = 0; i < N; i++) if (acc[i]) offer_v[i] = 0;
    end
    idle(8);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tag_return_arbiter.md
# tag_return_arbiter

Collects freed reservation-station tags from several completion sources and serialises them, one per cycle, onto the write port of the free-tag FIFO (`cdb_tag_tf` / `cdb_tag_tf_valid`). It sits between the functional-unit completion logic and the tag FIFO in the dispatch unit. It holds up to one pending tag per source, arbitrates round-robin, and never drives a write the FIFO would lose: no write when the FIFO is full, and no write in a cycle where the FIFO is being read.

## Interface
- `TAG_WIDTH`, 6: tag width in bits.
- `NUM_SRC`, 4: number of completion sources (2..8).
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `flush`  in  1: synchronous pipeline flush; discards all pending tags.
- `src_valid`  in  NUM_SRC: source i offers a tag.
- `src_tag`  in  NUM_SRC*TAG_WIDTH: tag of source i at bits [i*TAG_WIDTH +: TAG_WIDTH].
- `src_ready`  out  NUM_SRC: the holding slot for source i can accept a tag this cycle.
- `ren_tf`  in  1: tag FIFO read enable (dispatch is consuming a tag this cycle).
- `ff_tf`  in  1: tag FIFO full flag.
- `cdb_tag_tf`  out  TAG_WIDTH: tag written to the tag FIFO.
- `cdb_tag_tf_valid`  out  1: write strobe to the tag FIFO.
- `pending`  out  clog2(NUM_SRC+1): number of occupied holding slots (registered).

## Operation
- State per source i:
  - `held_v[i]`, the slot-occupied flag.
  - `held_tag[i]`, the held tag.
- Global state: round-robin pointer `rr`, width clog2(NUM_SRC), range 0..NUM_SRC-1.
- Reset values:
  - `held_v` = 0, `held_tag` = 0, `rr` = 0, `pending` = 0.
  - `cdb_tag_tf_valid` = 0, `cdb_tag_tf` = 0.
  - `src_ready` = all ones.
- Issue condition (combinational): `can_issue` = |`held_v` & ~`ren_tf` & ~`ff_tf` & ~`flush`.
- Winner selection: the first i with `held_v[i]`, searching `rr`, `rr`+1, … modulo NUM_SRC.
- Outputs:
  - `cdb_tag_tf_valid` = `can_issue`.
  - `cdb_tag_tf` = `held_tag[winner]` when `can_issue`, else 0.
- `src_ready[i]` = ~`flush` & (~`held_v[i]` | (`can_issue` & winner==i)). A slot freed by issue can be refilled in the same cycle.
- Accept: when `src_valid[i]` & `src_ready[i]`, the slot is set at the clock edge: `held_v[i]` <= 1, `held_tag[i]` <= the source's tag.
- Issue: at the clock edge the winner's `held_v` is cleared (unless refilled the same cycle) and `rr` <= winner+1, wrapping NUM_SRC-1 → 0. When there is no issue, `rr` is unchanged.
- Flush (synchronous, takes priority over accept and issue):
  - At the edge: `held_v` <= 0, `rr` <= 0.
  - During the flush cycle: no write, no accept.
  - Discarded tags are not recovered here; the tag FIFO restores its default contents on the same flush.
- `pending` <= popcount of next-state `held_v`.
- `src_valid` with `src_ready` low is not an error. The source holds its tag and retries; the block never drops an accepted tag except on flush or reset.

## Timing
- Latency: a tag accepted at edge N can appear on `cdb_tag_tf` in cycle N+1 (combinational after the slot register). Minimum source-to-FIFO latency is 1 cycle.
- Throughput: one tag per cycle, whenever `ren_tf` = 0 and `ff_tf` = 0.
- `ren_tf` = 1 blocks the write in that cycle, because the FIFO prioritises read over write and would drop the tag. The winner and `rr` are held; the write retries next cycle.
- `ff_tf` = 1 blocks the write. Slots keep filling; sources see `src_ready` = 0 once their slot is full.
- `ren_tf` and `ff_tf` are same-cycle inputs. There is a combinational path to `cdb_tag_tf_valid`; there is no combinational path from `src_valid` to any output.
- Reset mid-operation: immediate clear of all state and outputs, independent of `clk`.

## Test plan
- **Reset:** assert `reset` asynchronously between edges → `cdb_tag_tf_valid`=0, `cdb_tag_tf`=0, `pending`=0, `src_ready`=4'b1111 immediately.
- **Single source:** src0 offers tag 6'h2A, `ren_tf`=`ff_tf`=0 → next cycle `cdb_tag_tf`=6'h2A, `cdb_tag_tf_valid`=1 for exactly one cycle; `pending` goes 1 then 0.
- **Round-robin:** all four sources offer tags 1,2,3,4 in one cycle → writes of 1,2,3,4 on four consecutive cycles. Next, sources 0 and 3 offer 9 and 12 → order 9 then 12 (rr=0 after wrap).
- **Read collision:** held tag 6'h05 with `ren_tf`=1 for 2 cycles → `cdb_tag_tf_valid`=0 both cycles; tag 6'h05 written in the first cycle with `ren_tf`=0; `rr` unchanged before that write.
- **Full:** `ff_tf`=1 while all sources keep `src_valid`=1 → after 1 cycle `pending`=4, `src_ready`=0, no write. Deassert `ff_tf` → 4 writes in round-robin order, and each slot is refilled in the same cycle its tag issues.
- **Flush:** 3 slots held, `flush`=1 for one cycle → no write and `src_ready`=0 that cycle; next cycle `pending`=0, `rr`=0, `src_ready`=4'b1111, no stale tag ever written.
